// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if -- byte-queue and transmitter handshake bundle for uart_tx_queue.
//
// Signals:
//   wr_en, wr_data, flush   producer side: push a byte, or discard everything queued
//   full, empty, level      queue occupancy as seen by the producer
//   tx_start, tx_data       one-cycle launch pulse and byte to the transmitter
//   tx_busy                 transmitter busy flag, rises one cycle after tx_start
//   drop_cnt                saturating count of rejected pushes (UART_TXQ_DROPCNT_EN only)
//
// Modports: slave = the queue itself, master = producer plus transmitter side.
// Optional feature macro: UART_TXQ_DROPCNT_EN adds drop_cnt.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;

`ifdef UART_TXQ_DROPCNT_EN
  logic [7:0]    drop_cnt;

  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, level, tx_start, tx_data, drop_cnt
  );
  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, level, tx_start, tx_data, drop_cnt
  );
`else
  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, level, tx_start, tx_data
  );
  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, level, tx_start, tx_data
  );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue -- byte FIFO feeding a UART transmitter through a start/busy handshake.
//
// Ports:
//   clk   sole clock, all state updates on the rising edge
//   rst   asynchronous, active-high reset
//   bus   uart_tx_queue_if.slave (wr_en/wr_data/flush in, full/empty/level out,
//         tx_start/tx_data out, tx_busy in, drop_cnt out when enabled)
//
// Parameter DEPTH: number of byte entries, power of two in 4..256.
// Optional feature macro: UART_TXQ_DROPCNT_EN enables the saturating rejected-push counter.
//
// A byte is launched by a one-cycle tx_start pulse; the FSM then waits for the
// transmitter to raise and drop tx_busy before launching the next byte, which
// gives at least two cycles from tx_busy falling to the next tx_start.
module uart_tx_queue #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tx_start;
  logic [7:0]    tx_data;

  // Flags come from the registered level only, so a push is judged against the
  // occupancy before any same-cycle pop: a full queue rejects even while popping.
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = bus.wr_en && !full && !bus.flush;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_data;

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        // A flush cycle never launches, so the byte it discards cannot escape.
        if (!empty && !bus.tx_busy && !bus.flush) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_next;
      // tx_start is high only in the cycle after a launch, i.e. while in START.
      tx_start <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      // Already-launched byte lives in tx_data and the FSM, both untouched here.
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving reset off lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

`ifdef UART_TXQ_DROPCNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (bus.wr_en && full && !bus.flush && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt;
`endif
endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of 2, range 4..256.
REQ-002 SHALL have localparam AW = log2(DEPTH), pointer width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  push request for wr_data.
REQ-006 SHALL have port wr_data  input  8  byte to queue.
REQ-007 SHALL have port flush  input  1  discard all queued bytes.
REQ-008 SHALL have port full  output  1  high when level==DEPTH.
REQ-009 SHALL have port empty  output  1  high when level==0.
REQ-010 SHALL have port level  output  AW+1  number of queued bytes.
REQ-011 SHALL have port tx_start  output  1  one-cycle start pulse to the downstream transmitter.
REQ-012 SHALL have port tx_data  output  8  byte to send; valid while tx_start is high.
REQ-013 SHALL have port tx_busy  input  1  transmitter busy flag; rises one cycle after the accepted start.
REQ-014 SHALL have port drop_cnt  output  8  rejected-push count; present only with UART_TXQ_DROPCNT_EN.

Function
REQ-015 SHALL store bytes in a DEPTH x 8 circular buffer with wr_ptr/rd_ptr of AW bits wrapping DEPTH-1 -> 0.
REQ-016 SHALL accept a push when wr_en && !full && !flush, sampling full before any same-cycle pop.
REQ-017 SHALL reject a push when full, even if a pop occurs in the same cycle; the byte is discarded and the queue is unchanged.
REQ-018 SHALL, on simultaneous accepted push and pop, leave level unchanged and advance both pointers.
REQ-019 SHALL use an FSM with states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-020 SHALL, in IDLE with !empty && !tx_busy && !flush, register tx_data <= mem[rd_ptr], increment rd_ptr, decrement level, set tx_start=1, and enter START.
REQ-021 SHALL, in START, clear tx_start so the pulse is exactly one cycle wide, and enter WAIT_BUSY.
REQ-022 SHALL, in WAIT_BUSY, enter WAIT_DONE when tx_busy==1.
REQ-023 SHALL, in WAIT_DONE, return to IDLE when tx_busy==0.
REQ-024 SHALL hold tx_data stable from the tx_start pulse until the next pulse.
REQ-025 SHALL have a minimum spacing of 2 cycles from tx_busy falling to the next tx_start.
REQ-026 SHALL never pop from an empty queue; a push into an empty queue is first visible to the FSM on the following cycle (no bypass).
REQ-027 SHALL, on flush, set wr_ptr=rd_ptr=0 and level=0 in one cycle, without affecting the FSM state or any byte already launched.
REQ-028 SHALL give flush priority over wr_en in the same cycle.
REQ-029 SHALL derive full and empty combinationally from registered level.

Reset
REQ-030 SHALL, on rst asserted, set state=IDLE, pointers=0, level=0, tx_start=0, tx_data=8'h00, and drop_cnt=0, regardless of clk.
REQ-031 SHALL make empty=1 and full=0 during reset.
REQ-032 SHALL discard any in-flight byte if rst is asserted mid-transfer; after release, the FSM ignores tx_busy until the queue is non-empty.

Configuration
REQ-033 SHALL, with UART_TXQ_DROPCNT_EN defined, increment drop_cnt on each rejected push (wr_en && full && !flush) and saturate at 8'hFF.
REQ-034 SHALL, with UART_TXQ_DROPCNT_EN undefined, omit the drop_cnt port and its logic, with all other behaviour identical.

Verification
REQ-035 SHALL verify: push 8'h41 into an idle empty queue with tx_busy=0 -> tx_start is high exactly 1 cycle, 2 cycles after the push, with tx_data=8'h41 and level back to 0.
REQ-036 SHALL verify: push 8'h01..8'h03 with a transmitter model busy 10 cycles per byte -> three tx_start pulses, data 01,02,03 in order, each pulse at least 2 cycles after tx_busy falls.
REQ-037 SHALL verify: with DEPTH=16 and tx_busy held at 1, push 17 bytes -> full=1 and level=16 after 16 pushes; 17th rejected; drop_cnt=1 with macro defined.
REQ-038 SHALL verify: full queue, pop and push in the same cycle -> push rejected and level=15.
REQ-039 SHALL verify: 5 bytes queued, flush and wr_en high in the same cycle -> level=0, empty=1, and the launched byte completes without another tx_start.
REQ-040 SHALL verify: rst asserted during WAIT_DONE -> all outputs reach reset values asynchronously, and the FSM is in IDLE with no tx_start after release.
